// File: rtl/hazard_dest_pipe.sv
// Tracks destination register, instruction class and valid bit through EX/MEM/WB
// and raises the load-use stall / bubble controls for IF/ID and ID/EX.
`ifndef INS_ID_RTYPE
`define INS_ID_RTYPE 3'b001
`endif
`ifndef INS_ID_LW
`define INS_ID_LW 3'b010
`endif

module hazard_dest_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ready,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rd_id,
    input  logic [2:0]  INS_ID_id,
    input  logic        id_valid,
    input  logic        uses_rt_id,
    input  logic        flush_id,
    output logic [4:0]  rd_ex,
    output logic [4:0]  rd_mem,
    output logic [4:0]  rd_wb,
    output logic [2:0]  INS_ID_ex,
    output logic [2:0]  INS_ID_mem,
    output logic [2:0]  INS_ID_wb,
    output logic        valid_ex,
    output logic        valid_mem,
    output logic        valid_wb,
    output logic        stall_if_id,
    output logic        bubble_ex,
    output logic [15:0] stall_count
);

    logic [4:0]  rd_ex_q, rd_mem_q, rd_wb_q, rd_ex_d, rd_mem_d, rd_wb_d;
    logic [2:0]  ins_ex_q, ins_mem_q, ins_wb_q, ins_ex_d, ins_mem_d, ins_wb_d;
    logic        valid_ex_q, valid_mem_q, valid_wb_q, valid_ex_d, valid_mem_d, valid_wb_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic id_live, ex_lw_hit, mem_lw_hit, load_use;

    // Loads forward only from WB, so a matching load in EX or MEM must stall.
    always_comb begin
        id_live    = id_valid && !flush_id;
        ex_lw_hit  = valid_ex_q && (ins_ex_q == `INS_ID_LW) && (rd_ex_q != 5'd0) &&
                     ((rd_ex_q == rs_id) || (uses_rt_id && (rd_ex_q == rt_id)));
        mem_lw_hit = valid_mem_q && (ins_mem_q == `INS_ID_LW) && (rd_mem_q != 5'd0) &&
                     ((rd_mem_q == rs_id) || (uses_rt_id && (rd_mem_q == rt_id)));
        load_use   = id_live && (ex_lw_hit || mem_lw_hit);
    end

    // mem_ready is a completion strobe: while low, every tracked stage holds.
    always_comb begin
        rd_ex_d       = rd_ex_q;
        rd_mem_d      = rd_mem_q;
        rd_wb_d       = rd_wb_q;
        ins_ex_d      = ins_ex_q;
        ins_mem_d     = ins_mem_q;
        ins_wb_d      = ins_wb_q;
        valid_ex_d    = valid_ex_q;
        valid_mem_d   = valid_mem_q;
        valid_wb_d    = valid_wb_q;
        stall_if_id   = 1'b0;
        bubble_ex     = 1'b0;
        stall_count_d = stall_count_q;
        if (rst) begin
            stall_if_id = 1'b0;
            bubble_ex   = 1'b0;
        end else if (!mem_ready) begin
            stall_if_id = 1'b1;
        end else begin
            rd_wb_d     = rd_mem_q;
            ins_wb_d    = ins_mem_q;
            valid_wb_d  = valid_mem_q;
            rd_mem_d    = rd_ex_q;
            ins_mem_d   = ins_ex_q;
            valid_mem_d = valid_ex_q;
            if (id_live && !load_use) begin
                rd_ex_d    = rd_id;
                ins_ex_d   = INS_ID_id;
                valid_ex_d = 1'b1;
            end else begin
                rd_ex_d    = 5'd0;
                ins_ex_d   = 3'b000;
                valid_ex_d = 1'b0;
                bubble_ex  = 1'b1;
            end
            stall_if_id = load_use;
        end
        if (stall_if_id && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ex_q       <= 5'd0;
            rd_mem_q      <= 5'd0;
            rd_wb_q       <= 5'd0;
            ins_ex_q      <= 3'b000;
            ins_mem_q     <= 3'b000;
            ins_wb_q      <= 3'b000;
            valid_ex_q    <= 1'b0;
            valid_mem_q   <= 1'b0;
            valid_wb_q    <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            rd_ex_q       <= rd_ex_d;
            rd_mem_q      <= rd_mem_d;
            rd_wb_q       <= rd_wb_d;
            ins_ex_q      <= ins_ex_d;
            ins_mem_q     <= ins_mem_d;
            ins_wb_q      <= ins_wb_d;
            valid_ex_q    <= valid_ex_d;
            valid_mem_q   <= valid_mem_d;
            valid_wb_q    <= valid_wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign rd_ex       = rd_ex_q;
    assign rd_mem      = rd_mem_q;
    assign rd_wb       = rd_wb_q;
    assign INS_ID_ex   = ins_ex_q;
    assign INS_ID_mem  = ins_mem_q;
    assign INS_ID_wb   = ins_wb_q;
    assign valid_ex    = valid_ex_q;
    assign valid_mem   = valid_mem_q;
    assign valid_wb    = valid_wb_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Bench for hazard_dest_pipe: directed vector table, hand-written corner sequences
// and random stimulus against a queue-based pipeline model.
module tb_hazard_dest_pipe;

    localparam logic [2:0] RTYPE = 3'b001;
    localparam logic [2:0] LW    = 3'b010;

    logic        clk = 1'b0;
    logic        rst, mem_ready, id_valid, uses_rt_id, flush_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic [2:0]  INS_ID_id;
    logic [4:0]  rd_ex, rd_mem, rd_wb;
    logic [2:0]  INS_ID_ex, INS_ID_mem, INS_ID_wb;
    logic        valid_ex, valid_mem, valid_wb, stall_if_id, bubble_ex;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_dest_pipe dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .INS_ID_id(INS_ID_id),
        .id_valid(id_valid), .uses_rt_id(uses_rt_id), .flush_id(flush_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .INS_ID_ex(INS_ID_ex), .INS_ID_mem(INS_ID_mem), .INS_ID_wb(INS_ID_wb),
        .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .stall_count(stall_count)
    );

    typedef struct { logic [4:0] rd; logic [2:0] ins; logic v; } rec_t;
    localparam rec_t BUB = '{rd: 5'd0, ins: 3'b000, v: 1'b0};

    // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB
    rec_t pipe[$];
    int   m_cnt;
    int   checks = 0;
    int   errors = 0;

    logic        s_stall, s_bub, s_vex;
    logic [4:0]  s_rd_ex, s_rd_wb;
    logic [2:0]  s_ins_wb;
    logic [15:0] s_cnt;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic hit(rec_t r);
        return r.v && (r.ins == LW) && (r.rd != 5'd0) &&
               ((r.rd == rs_id) || (uses_rt_id && (r.rd == rt_id)));
    endfunction

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [2:0] ins, input logic v, input logic u,
                       input logic f, input logic m, input logic r);
        rs_id = rs; rt_id = rt; rd_id = rd; INS_ID_id = ins;
        id_valid = v; uses_rt_id = u; flush_id = f; mem_ready = m; rst = r;
    endtask

    task automatic check_state();
        chk("rd_ex", rd_ex, pipe[0].rd);
        chk("rd_mem", rd_mem, pipe[1].rd);
        chk("rd_wb", rd_wb, pipe[2].rd);
        chk("ins_ex", INS_ID_ex, pipe[0].ins);
        chk("ins_mem", INS_ID_mem, pipe[1].ins);
        chk("ins_wb", INS_ID_wb, pipe[2].ins);
        chk("valid_ex", valid_ex, pipe[0].v);
        chk("valid_mem", valid_mem, pipe[1].v);
        chk("valid_wb", valid_wb, pipe[2].v);
        chk("stall_count", stall_count, m_cnt);
    endtask

    // One clock: inputs already driven at posedge+1; check controls at negedge,
    // advance the model across the edge, then check the stage registers.
    task automatic step();
        logic live, lu, e_stall, e_bub;
        rec_t nx;
        #4;
        live = id_valid && !flush_id;
        lu   = live && (hit(pipe[0]) || hit(pipe[1]));
        if (rst)            begin e_stall = 1'b0; e_bub = 1'b0;  end
        else if (!mem_ready) begin e_stall = 1'b1; e_bub = 1'b0;  end
        else if (lu)        begin e_stall = 1'b1; e_bub = 1'b1;  end
        else                begin e_stall = 1'b0; e_bub = !live; end
        s_stall = stall_if_id; s_bub = bubble_ex; s_vex = valid_ex;
        s_rd_ex = rd_ex; s_rd_wb = rd_wb; s_ins_wb = INS_ID_wb; s_cnt = stall_count;
        chk("stall_if_id", stall_if_id, e_stall);
        chk("bubble_ex", bubble_ex, e_bub);
        @(posedge clk);
        #1;
        if (rst) begin
            pipe  = '{BUB, BUB, BUB};
            m_cnt = 0;
        end else begin
            if (mem_ready) begin
                nx = (live && !lu) ? rec_t'{rd: rd_id, ins: INS_ID_id, v: 1'b1} : BUB;
                pipe.push_front(nx);
                void'(pipe.pop_back());
            end
            if (e_stall && m_cnt < 65535) m_cnt++;
        end
        check_state();
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 3'b000, 0, 0, 0, 1, 1);
        step();
    endtask

    task automatic nop();
        drv(0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
        step();
    endtask

    // Hold one consumer in ID until it is accepted; report the stall cycles seen.
    task automatic consume(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic u, output int stalls);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            drv(rs, rt, rd, RTYPE, 1, u, 0, 1, 0);
            step();
            if (s_stall) stalls++;
            else break;
        end
    endtask

    typedef struct {
        logic [4:0] rs, rt, rd; logic [2:0] ins; logic vld, urt;
        logic e_stall, e_bub; logic [4:0] e_rd_ex; logic e_vex;
        logic [4:0] e_rd_wb; logic [2:0] e_ins_wb; logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[5];
    int   n, c0;

    initial begin
        pipe  = '{BUB, BUB, BUB};
        m_cnt = 0;
        drv(0, 0, 0, 3'b000, 0, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_stall_count", stall_count, 0);
        chk("rst_valid_wb", valid_wb, 0);

        // LW r5 then ADD r7,r5,r6 back to back
        vecs[0] = '{5'd1, 5'd0, 5'd5, LW,     1, 0, 0, 0, 5'd0, 0, 5'd0, 3'b000, 16'd0};
        vecs[1] = '{5'd5, 5'd6, 5'd7, RTYPE,  1, 1, 1, 1, 5'd5, 1, 5'd0, 3'b000, 16'd0};
        vecs[2] = '{5'd5, 5'd6, 5'd7, RTYPE,  1, 1, 1, 1, 5'd0, 0, 5'd0, 3'b000, 16'd1};
        vecs[3] = '{5'd5, 5'd6, 5'd7, RTYPE,  1, 1, 0, 0, 5'd0, 0, 5'd5, LW,     16'd2};
        vecs[4] = '{5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 0, 1, 5'd7, 1, 5'd0, 3'b000, 16'd2};
        for (int i = 0; i < 5; i++) begin
            drv(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].ins, vecs[i].vld, vecs[i].urt, 0, 1, 0);
            step();
            chk($sformatf("vec%0d_stall", i), s_stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_bubble", i), s_bub, vecs[i].e_bub);
            chk($sformatf("vec%0d_rd_ex", i), s_rd_ex, vecs[i].e_rd_ex);
            chk($sformatf("vec%0d_valid_ex", i), s_vex, vecs[i].e_vex);
            chk($sformatf("vec%0d_rd_wb", i), s_rd_wb, vecs[i].e_rd_wb);
            chk($sformatf("vec%0d_ins_wb", i), s_ins_wb, vecs[i].e_ins_wb);
            chk($sformatf("vec%0d_count", i), s_cnt, vecs[i].e_cnt);
        end

        // One independent instruction between LW and an rt consumer
        do_reset();
        drv(1, 0, 5, LW, 1, 0, 0, 1, 0);    step();
        drv(1, 2, 8, RTYPE, 1, 1, 0, 1, 0); step();
        consume(3, 5, 9, 1, n);
        chk("gap1_rt_stalls", n, 1);
        do_reset();
        drv(1, 0, 5, LW, 1, 0, 0, 1, 0);    step();
        drv(1, 2, 8, RTYPE, 1, 1, 0, 1, 0); step();
        consume(3, 5, 9, 0, n);
        chk("gap1_no_rt_stalls", n, 0);

        // r0 never hazards; RTYPE producers never stall
        do_reset();
        drv(1, 0, 0, LW, 1, 0, 0, 1, 0); step();
        consume(0, 0, 9, 1, n);
        chk("lw_r0_stalls", n, 0);
        do_reset();
        drv(1, 2, 3, RTYPE, 1, 1, 0, 1, 0); step();
        consume(3, 3, 4, 1, n);
        chk("rtype_stalls", n, 0);
        chk("rtype_rd_mem", rd_mem, 3);
        chk("rtype_ins_mem", INS_ID_mem, RTYPE);

        // Freeze with LW in MEM, then the load-use stall resumes
        do_reset();
        drv(1, 0, 5, LW, 1, 0, 0, 1, 0); step();
        nop();
        c0 = stall_count;
        for (int i = 0; i < 3; i++) begin
            drv(5, 6, 7, RTYPE, 1, 1, 0, 0, 0);
            step();
            chk("freeze_rd_mem", rd_mem, 5);
            chk("freeze_ins_mem", INS_ID_mem, LW);
        end
        chk("freeze_count", stall_count, c0 + 3);
        consume(5, 6, 7, 1, n);
        chk("after_freeze_stalls", n, 1);

        // Flush beats load-use
        do_reset();
        drv(1, 0, 5, LW, 1, 0, 0, 1, 0); step();
        drv(5, 6, 7, RTYPE, 1, 1, 1, 1, 0); step();
        chk("flush_stall", s_stall, 0);
        chk("flush_bubble", s_bub, 1);
        chk("flush_valid_ex", valid_ex, 0);

        // Reset mid-stall aborts it; the consumer proceeds right after
        do_reset();
        drv(1, 0, 5, LW, 1, 0, 0, 1, 0); step();
        drv(5, 6, 9, RTYPE, 1, 1, 0, 1, 0); step();
        chk("pre_rst_stall", s_stall, 1);
        drv(5, 6, 9, RTYPE, 1, 1, 0, 1, 1); step();
        chk("in_rst_stall", s_stall, 0);
        chk("in_rst_bubble", s_bub, 0);
        drv(5, 6, 9, RTYPE, 1, 1, 0, 1, 0); step();
        chk("post_rst_stall", s_stall, 0);
        chk("post_rst_valid_ex", valid_ex, 1);
        chk("post_rst_rd_ex", rd_ex, 9);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? LW : (($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : RTYPE),
                $urandom_range(0, 6) != 0, $urandom_range(0, 1),
                $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 49) == 0);
            step();
        end

        // Saturation of stall_count, then reset clears everything
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            drv(5, 6, 7, RTYPE, 1, 1, 0, 0, 0);
            step();
        end
        chk("sat_count", stall_count, 16'hFFFF);
        drv(5, 6, 7, RTYPE, 1, 1, 0, 0, 1); step();
        chk("final_rst_count", stall_count, 0);
        chk("final_rst_rd", {rd_ex, rd_mem, rd_wb}, 0);
        chk("final_rst_valid", {valid_ex, valid_mem, valid_wb}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_dest_pipe.md
HAZARD_DEST_PIPE -- requirements
Module: hazard_dest_pipe

Interface
REQ-001 The block SHALL have these ports, clock and reset first; clk, rst and mem_ready are listed in requirement 002, and all other ports are in requirements 003-016.
REQ-002 The block SHALL have: clk input 1, the single clock; rst input 1, synchronous active-high reset; mem_ready input 1, high when data memory completes this cycle.
REQ-003 rs_id  input  5  rs field of the instruction in ID.
REQ-004 rt_id  input  5  rt field of the instruction in ID.
REQ-005 rd_id  input  5  destination register of the instruction in ID (already muxed rd/rt by decode).
REQ-006 INS_ID_id  input  3  instruction class of the ID instruction, `INS_ID_* encodings from instruction_def.v.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 uses_rt_id  input  1  ID instruction reads rt as a source.
REQ-009 flush_id  input  1  taken branch/jump: squash the instruction in ID.
REQ-010 rd_ex, rd_mem, rd_wb  output  5 each  destination register tracked in EX/MEM/WB.
REQ-011 INS_ID_ex, INS_ID_mem, INS_ID_wb  output  3 each  instruction class tracked in EX/MEM/WB.
REQ-012 valid_ex, valid_mem, valid_wb  output  1 each  stage holds a real instruction.
REQ-013 stall_if_id  output  1  hold PC and IF/ID register this cycle (combinational).
REQ-014 bubble_ex  output  1  ID/EX register loads a bubble this cycle (combinational).
REQ-015 stall_count  output  16  saturating count of cycles with stall_if_id=1.
REQ-016 The producer side of the forwarding interface SHALL be rd_mem, rd_wb, INS_ID_mem and INS_ID_wb, which drive the forwarding unit directly.

Function
REQ-017 Bubble encoding SHALL be rd=0, INS_ID=3'b000, valid=0; rd=0 guarantees no forwarding from a bubble.
REQ-018 Tracked writers SHALL be instructions with INS_ID equal to `INS_ID_RTYPE or `INS_ID_LW and with valid=1 and rd!=0; no other class creates a hazard.
REQ-019 id_live SHALL equal id_valid AND NOT flush_id.
REQ-020 load_use SHALL assert when id_live and a valid `INS_ID_LW with rd!=0 sits in EX or MEM and rd equals rs_id, or equals rt_id with uses_rt_id=1; this covers both EX and MEM because loads forward only from WB.
REQ-021 Per-cycle priority SHALL be: rst, then mem_ready=0 (freeze), then load_use (bubble), then normal advance.
REQ-022 Freeze: when mem_ready=0, all EX/MEM/WB registers SHALL hold; stall_if_id=1; bubble_ex=0.
REQ-023 Bubble: when load_use=1 and mem_ready=1, EX SHALL load the bubble, MEM<=EX, WB<=MEM; stall_if_id=1; bubble_ex=1.
REQ-024 Advance: otherwise EX SHALL load {rd_id, INS_ID_id, 1} if id_live, else the bubble; MEM<=EX, WB<=MEM; stall_if_id=0; bubble_ex=NOT id_live.
REQ-025 Load-use latency: a consumer directly behind a LW SHALL stall exactly 2 cycles; one with a single instruction between SHALL stall 1 cycle (with mem_ready=1 throughout).
REQ-026 flush_id together with a load_use match SHALL NOT stall; the squashed instruction SHALL enter EX as a bubble.
REQ-027 stall_count SHALL increment by 1 on each clock edge where stall_if_id=1 and SHALL saturate at 16'hFFFF.
REQ-028 Register writes, including rd=0 and non-tracked classes, SHALL pass through unchanged; only hazard evaluation filters them.

Reset
REQ-029 On rst=1 at a clock edge, all stage registers SHALL become the bubble and stall_count SHALL become 0, regardless of mem_ready.
REQ-030 While rst=1, stall_if_id and bubble_ex SHALL be 0.
REQ-031 Reset asserted mid-stall SHALL abort the stall; the ID instruction proceeds normally on the first cycle after rst deasserts.

Verification
REQ-032 LW r5 then ADD r7,r5,r6 back-to-back -> stall_if_id=1 for 2 cycles, two bubbles in EX, ADD reaches EX when LW is in WB (rd_wb=5, INS_ID_wb=LW), stall_count=2.
REQ-033 LW r5, independent RTYPE, then SUB using rt=r5 with uses_rt_id=1 -> exactly 1 stall cycle; with uses_rt_id=0 -> 0 stalls.
REQ-034 LW r0 then a consumer of r0 -> no stall; RTYPE r3 followed by a consumer of r3 -> no stall, rd_mem=3 and INS_ID_mem=RTYPE on the next cycle.
REQ-035 mem_ready=0 for 3 cycles with LW in MEM -> all stage outputs frozen, stall_count +3, then the load-use stall resumes correctly.
REQ-036 A load_use condition with flush_id=1 -> stall_if_id=0, bubble_ex=1, valid_ex=0 on the next cycle.
REQ-037 stall_count preloaded near 16'hFFFF by a long mem_ready=0 run -> holds at 16'hFFFF; rst -> 0 and all rd_*=0, valid_*=0.
